loom_axil_regs: RTL and testbench
=================================

// Module: loom_axil_regs
// PURPOSE
//  AXI-Lite subordinate register bank; terminates the destination (m_axi_*) side of the AXI-Lite clock converter.
//  Holds NUM_REGS 32-bit software-visible control registers, exposed to fabric logic as a flat vector.
//  Emits one-cycle per-register write pulses. Single clock domain, no CDC inside.
// PARAMETERS
//  NUM_REGS     16            number of 32-bit registers, word-addressed from offset 0x0 (1..256)
//  RESET_VALUE  32'h0         reset value of every register
//  ID_VALUE     32'h4C4F4F4D  constant returned at word 0 when LOOM_AXIL_ID_REG_EN is defined
// PORTS
//  s_axi_aclk     in   1            clock
//  s_axi_aresetn  in   1            asynchronous reset, active-low
//  s_axi_awaddr   in   20           write address (byte)
//  s_axi_awprot   in   3            ignored
//  s_axi_awvalid  in   1            / s_axi_awready out 1: AW handshake
//  s_axi_wdata    in   32           write data
//  s_axi_wstrb    in   4            byte strobes
//  s_axi_wvalid   in   1            / s_axi_wready out 1: W handshake
//  s_axi_bresp    out  2            write response
//  s_axi_bvalid   out  1            / s_axi_bready in 1: B handshake
//  s_axi_araddr   in   20           read address (byte)
//  s_axi_arprot   in   3            ignored
//  s_axi_arvalid  in   1            / s_axi_arready out 1: AR handshake
//  s_axi_rdata    out  32           read data
//  s_axi_rresp    out  2            read response
//  s_axi_rvalid   out  1            / s_axi_rready in 1: R handshake
//  regs_o         out  32*NUM_REGS  register contents; reg i at [32*i +: 32]
//  wr_pulse_o     out  NUM_REGS     1-cycle pulse on committed OKAY write to reg i
// BEHAVIOUR
//  Reset (async assert, sync deassert by upstream): all ready/valid outputs 0, bresp/rresp/rdata 0,
//   wr_pulse_o 0, regs = RESET_VALUE, AW/W holding flags cleared. Asserting mid-transaction drops it silently.
//  Decode: idx = addr[19:2]; addr[1:0] ignored; idx >= NUM_REGS -> DECERR (2'b11), no side effect.
//  Write path: AW and W accepted independently, in either order or together.
//   awready = ~aw_held & ~bvalid; wready = ~w_held & ~bvalid (no combinational path from valid to ready).
//   commit when (aw_held|aw_hs) & (w_held|w_hs): on that edge, bytes with wstrb=1 update, other bytes keep,
//   wr_pulse_o[idx] pulses, bvalid rises, holds clear. Latency: bvalid 1 cycle after the later AW/W handshake.
//   bvalid/bresp stable until bready; no AW/W accepted while bvalid=1. wstrb=0 -> OKAY, no data change, pulse fires.
//  Read path: arready = ~rvalid. AR handshake at edge N -> rvalid, rdata, rresp registered at edge N; held until rready.
//   Next AR accepted the cycle after R handshake (max 1 outstanding read, 1 outstanding write).
//   DECERR reads return rdata = 0.
//  Simultaneous AR and write commit to same reg on same edge: read returns the pre-write value.
//  Reads and writes are independent; neither path stalls the other.
// CONFIGURATION
//  LOOM_AXIL_ID_REG_EN defined: word 0 is read-only, reads return ID_VALUE with OKAY; writes to word 0 -> SLVERR (2'b10),
//   no update, no pulse; regs_o[31:0] = ID_VALUE. Not defined: word 0 is an ordinary RW register.
// STRUCTURE
//  loom_axil_pkg: AXIL_ADDR_W=20, AXIL_DATA_W=32, axil_resp_e {OKAY=2'b00, SLVERR=2'b10, DECERR=2'b11}.
//  Sub-module loom_axil_wjoin: AW/W capture holds and commit strobe; register array and read mux stay in top.
// TESTING
//  1 AW+W same cycle, addr 0x8, data 0xDEADBEEF, strb 4'hF -> bvalid next cycle, OKAY, regs_o word 2 = 0xDEADBEEF, wr_pulse_o[2] 1 cycle.
//  2 W 3 cycles before AW, addr 0x4, data 0x11223344, strb 4'b0101 over 0xAAAAAAAA -> word 1 = 0xAA22AA44, bvalid 1 cycle after AW.
//  3 Read addr 0x8 with rready low 5 cycles -> rdata 0xDEADBEEF, rvalid held stable, arready 0 until R handshake.
//  4 Write/read addr 0x40 (NUM_REGS=16) -> DECERR both, rdata 0, no regs_o change, no pulse.
//  5 With LOOM_AXIL_ID_REG_EN: read 0x0 -> 0x4C4F4F4D OKAY; write 0x0 -> SLVERR, value unchanged.
//  6 aresetn low while bvalid=1 and aw_held=1 -> bvalid 0, all regs = RESET_VALUE; next write completes normally.

Source files
------------

// File: rtl/loom_axil_pkg.sv
// Shared AXI-Lite types for the loom register bank.
// Widths, response codes and the write request bundle.
package loom_axil_pkg;

  localparam int AXIL_ADDR_W = 20;
  localparam int AXIL_DATA_W = 32;
  localparam int AXIL_STRB_W = AXIL_DATA_W / 8;
  localparam int IDX_W       = AXIL_ADDR_W - 2;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } axil_resp_e;

  typedef struct packed {
    logic [IDX_W-1:0]       idx;
    logic [AXIL_DATA_W-1:0] data;
    logic [AXIL_STRB_W-1:0] strb;
  } wr_req_t;

  function automatic logic [AXIL_DATA_W-1:0] apply_strb(
    input logic [AXIL_DATA_W-1:0] old_v,
    input logic [AXIL_DATA_W-1:0] new_v,
    input logic [AXIL_STRB_W-1:0] strb
  );
    logic [AXIL_DATA_W-1:0] r;
    for (int b = 0; b < AXIL_STRB_W; b++) begin
      r[8*b +: 8] = strb[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/loom_axil_wjoin.sv
// Joins independent AW and W channels into one write commit.
// Either side may arrive first; the early one is held here.
module loom_axil_wjoin
  import loom_axil_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [IDX_W-1:0]       aw_idx,
  input  logic                   awvalid,
  output logic                   awready,
  input  logic [AXIL_DATA_W-1:0] wdata,
  input  logic [AXIL_STRB_W-1:0] wstrb,
  input  logic                   wvalid,
  output logic                   wready,
  input  logic                   b_busy,
  output logic                   commit,
  output wr_req_t                req
);

  logic                   aw_held;
  logic [IDX_W-1:0]       aw_idx_q;
  logic                   w_held;
  logic [AXIL_DATA_W-1:0] w_data_q;
  logic [AXIL_STRB_W-1:0] w_strb_q;
  logic                   aw_hs;
  logic                   w_hs;

  // Ready depends only on registered state, never on valid.
  assign awready = ~aw_held & ~b_busy;
  assign wready  = ~w_held & ~b_busy;
  assign aw_hs   = awvalid & awready;
  assign w_hs    = wvalid & wready;
  assign commit  = (aw_held | aw_hs) & (w_held | w_hs);

  always_comb begin
    req      = '0;
    req.idx  = aw_held ? aw_idx_q : aw_idx;
    req.data = w_held ? w_data_q : wdata;
    req.strb = w_held ? w_strb_q : wstrb;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aw_held  <= 1'b0;
      aw_idx_q <= '0;
      w_held   <= 1'b0;
      w_data_q <= '0;
      w_strb_q <= '0;
    end else if (commit) begin
      aw_held <= 1'b0;
      w_held  <= 1'b0;
    end else begin
      if (aw_hs) begin
        aw_held  <= 1'b1;
        aw_idx_q <= aw_idx;
      end
      if (w_hs) begin
        w_held   <= 1'b1;
        w_data_q <= wdata;
        w_strb_q <= wstrb;
      end
    end
  end

endmodule

// File: rtl/loom_axil_regs.sv
// AXI-Lite register bank with per-register write pulses.
// Define LOOM_AXIL_ID_REG_EN to make word 0 a read-only ID.
module loom_axil_regs
  import loom_axil_pkg::*;
#(
  parameter int          NUM_REGS    = 16,
  parameter logic [31:0] RESET_VALUE = 32'h0,
  parameter logic [31:0] ID_VALUE    = 32'h4C4F4F4D
) (
  input  logic                     s_axi_aclk,
  input  logic                     s_axi_aresetn,
  input  logic [AXIL_ADDR_W-1:0]   s_axi_awaddr,
  input  logic [2:0]               s_axi_awprot,
  input  logic                     s_axi_awvalid,
  output logic                     s_axi_awready,
  input  logic [AXIL_DATA_W-1:0]   s_axi_wdata,
  input  logic [AXIL_STRB_W-1:0]   s_axi_wstrb,
  input  logic                     s_axi_wvalid,
  output logic                     s_axi_wready,
  output logic [1:0]               s_axi_bresp,
  output logic                     s_axi_bvalid,
  input  logic                     s_axi_bready,
  input  logic [AXIL_ADDR_W-1:0]   s_axi_araddr,
  input  logic [2:0]               s_axi_arprot,
  input  logic                     s_axi_arvalid,
  output logic                     s_axi_arready,
  output logic [AXIL_DATA_W-1:0]   s_axi_rdata,
  output logic [1:0]               s_axi_rresp,
  output logic                     s_axi_rvalid,
  input  logic                     s_axi_rready,
  output logic [32*NUM_REGS-1:0]   regs_o,
  output logic [NUM_REGS-1:0]      wr_pulse_o
);

`ifdef LOOM_AXIL_ID_REG_EN
  localparam bit IdEn = 1'b1;
`else
  localparam bit IdEn = 1'b0;
`endif

  localparam logic [IDX_W-1:0] NREG = IDX_W'(NUM_REGS);

  logic                   clk;
  logic                   rst_n;
  logic                   live_q;
  logic [31:0]            regs_q [NUM_REGS];
  logic [31:0]            view [NUM_REGS];
  logic                   commit;
  wr_req_t                req;
  logic                   w_in;
  logic                   w_ro;
  logic                   wr_ok;
  axil_resp_e             w_resp;
  logic                   bvalid_q;
  axil_resp_e             bresp_q;
  logic                   rvalid_q;
  axil_resp_e             rresp_q;
  logic [31:0]            rdata_q;
  logic [NUM_REGS-1:0]    pulse_q;
  logic [IDX_W-1:0]       ridx;
  logic                   r_in;
  logic [31:0]            rd_word;
  logic                   ar_hs;
  logic                   unused_bits;

  assign clk   = s_axi_aclk;
  assign rst_n = s_axi_aresetn;

  assign unused_bits = ^{s_axi_awprot, s_axi_arprot,
                         s_axi_awaddr[1:0], s_axi_araddr[1:0]};

  loom_axil_wjoin u_wjoin (
    .clk     (clk),
    .rst_n   (rst_n),
    .aw_idx  (s_axi_awaddr[AXIL_ADDR_W-1:2]),
    .awvalid (s_axi_awvalid),
    .awready (s_axi_awready),
    .wdata   (s_axi_wdata),
    .wstrb   (s_axi_wstrb),
    .wvalid  (s_axi_wvalid),
    .wready  (s_axi_wready),
    .b_busy  (bvalid_q | ~live_q),
    .commit  (commit),
    .req     (req)
  );

  assign w_in  = req.idx < NREG;
  assign w_ro  = IdEn && (req.idx == '0);
  assign wr_ok = w_in & ~w_ro;

  always_comb begin
    w_resp = OKAY;
    unique case (1'b1)
      !w_in:  w_resp = DECERR;
      w_ro:   w_resp = SLVERR;
      default: w_resp = OKAY;
    endcase
  end

  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      view[i] = (IdEn && i == 0) ? ID_VALUE : regs_q[i];
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_out
    assign regs_o[32*g +: 32] = view[g];
  end

  assign ridx  = s_axi_araddr[AXIL_ADDR_W-1:2];
  assign r_in  = ridx < NREG;
  assign ar_hs = s_axi_arvalid & s_axi_arready;

  always_comb begin
    rd_word = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (ridx == IDX_W'(i)) rd_word = view[i];
    end
  end

  // Register array and write pulses; reads sample the pre-write view.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pulse_q <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= RESET_VALUE;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        pulse_q[i] <= commit & wr_ok & (req.idx == IDX_W'(i));
        if (commit && wr_ok && req.idx == IDX_W'(i)) begin
          regs_q[i] <= apply_strb(regs_q[i], req.data, req.strb);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      live_q   <= 1'b0;
      bvalid_q <= 1'b0;
      bresp_q  <= OKAY;
    end else begin
      live_q <= 1'b1;
      if (commit) begin
        bvalid_q <= 1'b1;
        bresp_q  <= w_resp;
      end else if (bvalid_q && s_axi_bready) begin
        bvalid_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid_q <= 1'b0;
      rresp_q  <= OKAY;
      rdata_q  <= '0;
    end else if (ar_hs) begin
      rvalid_q <= 1'b1;
      rresp_q  <= r_in ? OKAY : DECERR;
      rdata_q  <= r_in ? rd_word : '0;
    end else if (rvalid_q && s_axi_rready) begin
      rvalid_q <= 1'b0;
    end
  end

  assign s_axi_bvalid  = bvalid_q;
  assign s_axi_bresp   = bresp_q;
  assign s_axi_arready = ~rvalid_q & live_q;
  assign s_axi_rvalid  = rvalid_q;
  assign s_axi_rresp   = rresp_q;
  assign s_axi_rdata   = rdata_q;
  assign wr_pulse_o    = pulse_q;

endmodule

// File: tb/tb_loom_axil_regs.sv
// Directed bench for loom_axil_regs (default 16 registers).
// Word 0 expectations follow LOOM_AXIL_ID_REG_EN.
module tb_loom_axil_regs;

  localparam int N = 16;
  localparam logic [31:0] ID = 32'h4C4F4F4D;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [19:0]   awaddr = '0;
  logic [2:0]    awprot = '0;
  logic          awvalid = 1'b0;
  logic          awready;
  logic [31:0]   wdata = '0;
  logic [3:0]    wstrb = '0;
  logic          wvalid = 1'b0;
  logic          wready;
  logic [1:0]    bresp;
  logic          bvalid;
  logic          bready = 1'b0;
  logic [19:0]   araddr = '0;
  logic [2:0]    arprot = '0;
  logic          arvalid = 1'b0;
  logic          arready;
  logic [31:0]   rdata;
  logic [1:0]    rresp;
  logic          rvalid;
  logic          rready = 1'b0;
  logic [32*N-1:0] regs;
  logic [N-1:0]  pulse;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_w [N];

  always #5 clk = ~clk;

  loom_axil_regs dut (
    .s_axi_aclk    (clk),
    .s_axi_aresetn (rst_n),
    .s_axi_awaddr  (awaddr),
    .s_axi_awprot  (awprot),
    .s_axi_awvalid (awvalid),
    .s_axi_awready (awready),
    .s_axi_wdata   (wdata),
    .s_axi_wstrb   (wstrb),
    .s_axi_wvalid  (wvalid),
    .s_axi_wready  (wready),
    .s_axi_bresp   (bresp),
    .s_axi_bvalid  (bvalid),
    .s_axi_bready  (bready),
    .s_axi_araddr  (araddr),
    .s_axi_arprot  (arprot),
    .s_axi_arvalid (arvalid),
    .s_axi_arready (arready),
    .s_axi_rdata   (rdata),
    .s_axi_rresp   (rresp),
    .s_axi_rvalid  (rvalid),
    .s_axi_rready  (rready),
    .regs_o        (regs),
    .wr_pulse_o    (pulse)
  );

  task automatic chk(input string tag, input logic [511:0] obs,
                     input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_regs(input string tag);
    logic [32*N-1:0] v;
    for (int i = 0; i < N; i++) v[32*i +: 32] = exp_w[i];
    chk(tag, regs, v);
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) exp_w[i] = 32'h0;
`ifdef LOOM_AXIL_ID_REG_EN
    exp_w[0] = ID;
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_both(input logic [19:0] a, input logic [31:0] d,
                         input logic [3:0] s);
    awaddr = a; wdata = d; wstrb = s;
    awvalid = 1'b1; wvalid = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
  endtask

  task automatic rd(input logic [19:0] a);
    araddr = a; arvalid = 1'b1;
    tick();
    arvalid = 1'b0;
  endtask

  task automatic b_ack();
    bready = 1'b1;
    tick();
    bready = 1'b0;
  endtask

  task automatic r_ack();
    rready = 1'b1;
    tick();
    rready = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
  endtask

  initial begin
    model_reset();
    tick();
    chk("rst_awready", awready, 1'b0);
    chk("rst_arready", arready, 1'b0);
    chk("rst_bvalid", bvalid, 1'b0);
    chk("rst_rvalid", rvalid, 1'b0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_pulse", pulse, '0);
    chk_regs("rst_regs");
    #1 rst_n = 1'b1;
    tick();
    chk("live_awready", awready, 1'b1);
    chk("live_wready", wready, 1'b1);
    chk("live_arready", arready, 1'b1);

    // 1: AW+W together
    wr_both(20'h8, 32'hDEADBEEF, 4'hF);
    exp_w[2] = 32'hDEADBEEF;
    chk("t1_bvalid", bvalid, 1'b1);
    chk("t1_bresp", bresp, 2'b00);
    chk("t1_pulse", pulse, 16'h0004);
    chk("t1_awready", awready, 1'b0);
    chk_regs("t1_regs");
    tick();
    chk("t1_pulse_gone", pulse, 16'h0000);
    chk("t1_bvalid_hold", bvalid, 1'b1);
    b_ack();
    chk("t1_bvalid_clr", bvalid, 1'b0);

    // 2: W three cycles ahead of AW, partial strobes
    wr_both(20'h4, 32'hAAAAAAAA, 4'hF);
    exp_w[1] = 32'hAAAAAAAA;
    b_ack();
    wdata = 32'h11223344; wstrb = 4'b0101; wvalid = 1'b1;
    tick();
    wvalid = 1'b0;
    chk("t2_wready_held", wready, 1'b0);
    chk("t2_awready", awready, 1'b1);
    tick();
    tick();
    chk("t2_no_bvalid", bvalid, 1'b0);
    awaddr = 20'h4; awvalid = 1'b1;
    tick();
    awvalid = 1'b0;
    exp_w[1] = 32'hAA22AA44;
    chk("t2_bvalid", bvalid, 1'b1);
    chk("t2_pulse", pulse, 16'h0002);
    chk_regs("t2_regs");
    b_ack();

    // 3: read held while rready low
    rd(20'h8);
    chk("t3_rvalid", rvalid, 1'b1);
    chk("t3_rdata", rdata, 32'hDEADBEEF);
    chk("t3_rresp", rresp, 2'b00);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t3_hold_rvalid", rvalid, 1'b1);
      chk("t3_hold_rdata", rdata, 32'hDEADBEEF);
      chk("t3_hold_arready", arready, 1'b0);
    end
    r_ack();
    chk("t3_rvalid_clr", rvalid, 1'b0);
    chk("t3_arready_back", arready, 1'b1);

    // 4: out-of-range word
    wr_both(20'h40, 32'h12345678, 4'hF);
    chk("t4_bresp", bresp, 2'b11);
    chk("t4_pulse", pulse, 16'h0000);
    chk_regs("t4_regs");
    b_ack();
    rd(20'h40);
    chk("t4_rresp", rresp, 2'b11);
    chk("t4_rdata", rdata, 32'h0);
    r_ack();

    // last register, low address bits ignored
    wr_both(20'h3E, 32'hCAFEF00D, 4'hF);
    exp_w[15] = 32'hCAFEF00D;
    chk("last_pulse", pulse, 16'h8000);
    b_ack();
    rd(20'h3F);
    chk("last_rdata", rdata, 32'hCAFEF00D);
    chk("last_rresp", rresp, 2'b00);
    r_ack();

    // zero strobes still commit OKAY with a pulse
    wr_both(20'h8, 32'h0, 4'h0);
    chk("strb0_bresp", bresp, 2'b00);
    chk("strb0_pulse", pulse, 16'h0004);
    chk_regs("strb0_regs");
    b_ack();

    // read and write to same reg on one edge sees old value
    wr_both(20'hC, 32'h55555555, 4'hF);
    exp_w[3] = 32'h55555555;
    b_ack();
    araddr = 20'hC; arvalid = 1'b1;
    wr_both(20'hC, 32'h66666666, 4'hF);
    arvalid = 1'b0;
    exp_w[3] = 32'h66666666;
    chk("same_rdata", rdata, 32'h55555555);
    chk_regs("same_regs");
    b_ack();
    r_ack();

    // 5: word 0
`ifdef LOOM_AXIL_ID_REG_EN
    rd(20'h0);
    chk("id_rdata", rdata, ID);
    chk("id_rresp", rresp, 2'b00);
    r_ack();
    wr_both(20'h0, 32'h0BADF00D, 4'hF);
    chk("id_bresp", bresp, 2'b10);
    chk("id_pulse", pulse, 16'h0000);
    chk_regs("id_regs");
    b_ack();
`else
    wr_both(20'h0, 32'h0BADF00D, 4'hF);
    exp_w[0] = 32'h0BADF00D;
    chk("w0_bresp", bresp, 2'b00);
    chk("w0_pulse", pulse, 16'h0001);
    chk_regs("w0_regs");
    b_ack();
`endif

    // 6: reset with a response pending, then with AW held
    wr_both(20'h10, 32'h1, 4'hF);
    chk("t6_bvalid", bvalid, 1'b1);
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("t6_async_bvalid", bvalid, 1'b0);
    chk_regs("t6_async_regs");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    awaddr = 20'h14; awvalid = 1'b1;
    tick();
    awvalid = 1'b0;
    chk("t6_aw_held", awready, 1'b0);
    do_reset();
    chk("t6_awready_free", awready, 1'b1);
    wdata = 32'h77; wstrb = 4'hF; wvalid = 1'b1;
    tick();
    wvalid = 1'b0;
    chk("t6_no_stale_commit", bvalid, 1'b0);
    awaddr = 20'h14; awvalid = 1'b1;
    tick();
    awvalid = 1'b0;
    exp_w[5] = 32'h77;
    chk("t6_bvalid", bvalid, 1'b1);
    chk("t6_bresp", bresp, 2'b00);
    chk("t6_pulse", pulse, 16'h0020);
    chk_regs("t6_regs");
    b_ack();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
